// File: rtl/aux_arb_pkg.sv
// Shared types and constants for the auxiliary bus arbiter: FSM states, master ids,
// default widths and the data value returned by an aborted read.
package aux_arb_pkg;

    localparam int AUX_ADDR_WIDTH_DEF = 16;
    localparam int AUX_DATA_WIDTH_DEF = 8;
    localparam logic [7:0] ERR_DATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

endpackage

// File: rtl/aux_arb_rr.sv
// Two-way round-robin picker: a lone requester wins; on a tie the master that
// did not win last time is chosen.
module aux_arb_rr
    import aux_arb_pkg::*;
(
    input  logic [1:0]  req_i,
    input  master_id_e  last_grant_i,
    output master_id_e  grant_o,
    output logic        valid_o
);

    always_comb begin
        valid_o = |req_i;
        grant_o = M0;
        case (req_i)
            2'b01:   grant_o = M0;
            2'b10:   grant_o = M1;
            2'b11:   grant_o = (last_grant_i == M0) ? M1 : M0;
            default: grant_o = M0;
        endcase
    end

endmodule

// File: rtl/aux_bus_arbiter.sv
// Arbitrates a stallable CPU (master 0) and a request/ack host (master 1) onto one
// auxiliary slave bus. Optional slave timeout/abort is enabled by AUX_ARB_TIMEOUT_EN.
module aux_bus_arbiter
    import aux_arb_pkg::*;
#(
    parameter int AUX_ADDR_WIDTH = AUX_ADDR_WIDTH_DEF,
    parameter int AUX_DATA_WIDTH = AUX_DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [AUX_ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [AUX_DATA_WIDTH-1:0] m0_dat_i,
    output logic [AUX_DATA_WIDTH-1:0] m0_dat_o,
    input  logic                      m0_we_i,
    input  logic                      m0_re_i,
    output logic                      m0_clk_en_o,
    input  logic                      m1_req_i,
    input  logic                      m1_we_i,
    input  logic [AUX_ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [AUX_DATA_WIDTH-1:0] m1_dat_i,
    output logic [AUX_DATA_WIDTH-1:0] m1_dat_o,
    output logic                      m1_ack_o,
    output logic [AUX_ADDR_WIDTH-1:0] s_adr_o,
    output logic [AUX_DATA_WIDTH-1:0] s_dat_o,
    input  logic [AUX_DATA_WIDTH-1:0] s_dat_i,
    output logic                      s_we_o,
    output logic                      s_re_o,
    input  logic                      s_ack_i,
    output logic                      err_o
);

    arb_state_e                state_q, state_d;
    master_id_e                grant_q, grant_d;
    master_id_e                last_grant_q, last_grant_d;
    master_id_e                rr_grant;
    logic                      rr_valid;
    logic [AUX_ADDR_WIDTH-1:0] s_adr_q, s_adr_d;
    logic [AUX_DATA_WIDTH-1:0] s_dat_q, s_dat_d;
    logic [AUX_DATA_WIDTH-1:0] m0_dat_q, m0_dat_d;
    logic [AUX_DATA_WIDTH-1:0] m1_dat_q, m1_dat_d;
    logic [AUX_DATA_WIDTH-1:0] rd_data;
    logic                      s_we_q, s_we_d;
    logic                      s_re_q, s_re_d;
    logic                      m1_ack_q, m1_ack_d;
    logic                      m0_pending;
    logic                      timed_out;

    assign m0_pending = m0_we_i | m0_re_i;

    aux_arb_rr u_rr (
        .req_i        ({m1_req_i, m0_pending}),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant),
        .valid_o      (rr_valid)
    );

`ifdef AUX_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;

    // An acknowledge in the final allowed cycle still counts as a normal completion.
    assign timed_out = (state_q == XFER) && !s_ack_i &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign err_o     = err_q;
`else
    assign timed_out = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_adr_d      = s_adr_q;
        s_dat_d      = s_dat_q;
        s_we_d       = s_we_q;
        s_re_d       = s_re_q;
        m0_dat_d     = m0_dat_q;
        m1_dat_d     = m1_dat_q;
        m1_ack_d     = 1'b0;
        rd_data      = timed_out ? AUX_DATA_WIDTH'(ERR_DATA) : s_dat_i;
`ifdef AUX_ARB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        err_d        = err_q | timed_out;
`endif
        case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    grant_d      = rr_grant;
                    last_grant_d = rr_grant;
                    state_d      = XFER;
`ifdef AUX_ARB_TIMEOUT_EN
                    to_cnt_d     = '0;
`endif
                    if (rr_grant == M0) begin
                        s_adr_d = m0_adr_i;
                        s_dat_d = m0_dat_i;
                        s_we_d  = m0_we_i;
                        s_re_d  = !m0_we_i;
                    end else begin
                        s_adr_d = m1_adr_i;
                        s_dat_d = m1_dat_i;
                        s_we_d  = m1_we_i;
                        s_re_d  = !m1_we_i;
                    end
                end
            end
            XFER: begin
`ifdef AUX_ARB_TIMEOUT_EN
                to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                if (s_ack_i || timed_out) begin
                    s_we_d   = 1'b0;
                    s_re_d   = 1'b0;
                    state_d  = DONE;
                    m1_ack_d = (grant_q == M1);
                    if (s_re_q) begin
                        if (grant_q == M0) m0_dat_d = rd_data;
                        else               m1_dat_d = rd_data;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            grant_q      <= M0;
            last_grant_q <= M1;
            s_adr_q      <= '0;
            s_dat_q      <= '0;
            s_we_q       <= 1'b0;
            s_re_q       <= 1'b0;
            m0_dat_q     <= '0;
            m1_dat_q     <= '0;
            m1_ack_q     <= 1'b0;
`ifdef AUX_ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            s_adr_q      <= s_adr_d;
            s_dat_q      <= s_dat_d;
            s_we_q       <= s_we_d;
            s_re_q       <= s_re_d;
            m0_dat_q     <= m0_dat_d;
            m1_dat_q     <= m1_dat_d;
            m1_ack_q     <= m1_ack_d;
`ifdef AUX_ARB_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    // The CPU runs freely unless it is strobing and its transfer is not in the DONE cycle.
    assign m0_clk_en_o = !m0_pending || (state_q == DONE && grant_q == M0);
    assign m0_dat_o    = m0_dat_q;
    assign m1_dat_o    = m1_dat_q;
    assign m1_ack_o    = m1_ack_q;
    assign s_adr_o     = s_adr_q;
    assign s_dat_o     = s_dat_q;
    assign s_we_o      = s_we_q;
    assign s_re_o      = s_re_q;

endmodule
